// File: rtl/shr_delay_if.sv
// ---------------------------------------------------------------------------
// shr_delay_if
// Handshake bundle around the delay-line controller.
//   i_valid / i_ready / i_data : upstream item channel (accept = i_valid & i_ready)
//   o_valid / o_ready / o_data : downstream item channel (consume = o_valid & o_ready)
// Modports:
//   slave  : the controller side (receives upstream items, offers downstream items)
//   master : the environment side (producer upstream, consumer downstream)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface shr_delay_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_valid;
    logic                 i_ready;
    logic [DATA_BITS-1:0] i_data;
    logic                 o_valid;
    logic                 o_ready;
    logic [DATA_BITS-1:0] o_data;

    modport slave (
        input  i_valid,
        input  i_data,
        input  o_ready,
        output i_ready,
        output o_valid,
        output o_data
    );

    modport master (
        output i_valid,
        output i_data,
        output o_ready,
        input  i_ready,
        input  o_valid,
        input  o_data
    );
endinterface

// File: rtl/shr_delay_ctrl.sv
// ---------------------------------------------------------------------------
// shr_delay_ctrl
// Flow controller for an external clken-gated DEPTH-stage delay-line shift
// register (SI enters the top stage, SO is read from stage 0). Adds valid/ready
// handshakes on both sides, a per-stage valid tag line, an occupancy counter
// and a flush sequence that drains the line with bubbles.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : shr_delay_if.slave (upstream i_*, downstream o_*; o_data = sr_so)
//   flush_req  : 1-cycle pulse, drain all held items (honoured only in RUN)
//   flush_busy : high in FLUSH and DONE
//   flush_done : 1-cycle pulse once the line is empty after a flush
//   occupancy  : number of valid items held in the line
//   sr_clken   : shift enable to the external register
//   sr_si      : data into the external register top stage
//   sr_so      : data out of the external register stage 0
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal operation, upstream items pushed in as they arrive
// ST_FLUSH | input closed, bubbles pushed until every held item is out
// ST_DONE  | line empty, flush_done asserted for this single cycle
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module shr_delay_ctrl #(
    parameter int DEPTH     = 32,
    parameter int DATA_BITS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    shr_delay_if.slave                   bus,
    input  logic                         flush_req,
    output logic                         flush_busy,
    output logic                         flush_done,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         sr_clken,
    output logic [DATA_BITS-1:0]         sr_si,
    input  logic [DATA_BITS-1:0]         sr_so
);

    localparam int OCC_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [DEPTH-1:0]   vld;
    logic [OCC_W-1:0]   occ_q;
    logic [OCC_W-1:0]   occ_nxt;
    logic               busy_q;
    logic               done_q;

    logic               in_run;
    logic               in_flush;
    logic               push_src;
    logic               shift;
    logic               tag_in;
    logic               inc;
    logic               dec;

    always_comb begin
        in_run   = (state == ST_RUN);
        in_flush = (state == ST_FLUSH);
        // In FLUSH the source of pushes is bubbles, as long as anything is held.
        push_src = (in_run & bus.i_valid) | (in_flush & (occ_q != '0));
        // Stage 0 may only be overwritten when it is empty or being consumed,
        // so an item leaves the line exactly once.
        shift    = push_src & (~vld[0] | bus.o_ready);
        tag_in   = in_run;
        inc      = shift & tag_in;
        dec      = shift & vld[0];

        occ_nxt = occ_q;
        case ({inc, dec})
            2'b10:   occ_nxt = occ_q + OCC_W'(1);
            2'b01:   occ_nxt = occ_q - OCC_W'(1);
            default: occ_nxt = occ_q;
        endcase
    end

    assign sr_clken    = shift;
    assign sr_si       = in_run ? bus.i_data : '0;
    assign bus.i_ready = in_run & (~vld[0] | bus.o_ready);
    // Output only advances alongside a push, so it is offered only then.
    assign bus.o_valid = vld[0] & push_src;
    assign bus.o_data  = sr_so;
    assign occupancy   = occ_q;
    assign flush_busy  = busy_q;
    assign flush_done  = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            vld    <= '0;
            occ_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (shift) begin
                vld <= {tag_in, vld[DEPTH-1:1]};
            end
            occ_q <= occ_nxt;

            case (state)
                ST_RUN: begin
                    done_q <= 1'b0;
                    if (flush_req) begin
                        state  <= ST_FLUSH;
                        busy_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    busy_q <= 1'b1;
                    // Look at the post-shift count so the final decrement
                    // moves straight on to DONE.
                    if (occ_nxt == '0) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end else begin
                        done_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state  <= ST_RUN;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= ST_RUN;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shr_delay_ctrl.sv
`timescale 1ns/1ps
module tb_shr_delay_ctrl;

    localparam int DEPTH     = 4;
    localparam int DATA_BITS = 8;
    localparam int OCC_W     = $clog2(DEPTH+1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush_req;
    logic                 flush_busy;
    logic                 flush_done;
    logic [OCC_W-1:0]     occupancy;
    logic                 sr_clken;
    logic [DATA_BITS-1:0] sr_si;
    logic [DATA_BITS-1:0] sr_so;

    shr_delay_if #(.DATA_BITS(DATA_BITS)) bus ();

    shr_delay_ctrl #(.DEPTH(DEPTH), .DATA_BITS(DATA_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flush_req  (flush_req),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .occupancy  (occupancy),
        .sr_clken   (sr_clken),
        .sr_si      (sr_si),
        .sr_so      (sr_so)
    );

    always #5 clk = ~clk;

    // External delay-line register (no reset, like the real one).
    logic [DATA_BITS-1:0] sr_mem [DEPTH];
    always @(posedge clk) begin
        if (sr_clken) begin
            for (int i = 0; i < DEPTH-1; i++) sr_mem[i] <= sr_mem[i+1];
            sr_mem[DEPTH-1] <= sr_si;
        end
    end
    assign sr_so = sr_mem[0];

    // Consumption / pulse monitors.
    logic [DATA_BITS-1:0] outq [$];
    int n_clk;
    int done_cnt;
    always @(posedge clk) begin
        if (!rst && bus.o_valid && bus.o_ready) outq.push_back(bus.o_data);
        if (sr_clken) n_clk++;
        if (flush_done) done_cnt++;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Drive one cycle's inputs at the falling edge, settle, then return for checks.
    task automatic cyc(input logic r, input logic iv, input logic [DATA_BITS-1:0] id,
                       input logic ordy, input logic frq);
        @(negedge clk);
        rst         = r;
        bus.i_valid = iv;
        bus.i_data  = id;
        bus.o_ready = ordy;
        flush_req   = frq;
        #1;
    endtask

    task automatic chk_q(input string tag, input logic [DATA_BITS-1:0] exp [$]);
        chk({tag, "_cnt"}, outq.size(), exp.size());
        for (int i = 0; i < exp.size() && i < outq.size(); i++)
            chk($sformatf("%s_%0d", tag, i), outq[i], exp[i]);
    endtask

    initial begin
        logic seen;
        rst = 1'b1; bus.i_valid = 1'b0; bus.i_data = '0; bus.o_ready = 1'b1; flush_req = 1'b0;
        n_clk = 0; done_cnt = 0;

        // 1: reset state, fill, first output
        cyc(1, 0, 0, 1, 0);
        cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("rst_iready", bus.i_ready, 1);
        chk("rst_ovalid", bus.o_valid, 0);
        chk("rst_busy",   flush_busy, 0);
        chk("rst_done",   flush_done, 0);
        chk("rst_clken",  sr_clken, 0);
        chk("rst_occ",    occupancy, 0);
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 1, DATA_BITS'(k), 1, 0);
            chk($sformatf("fill%0d_ovalid", k), bus.o_valid, 0);
            chk($sformatf("fill%0d_iready", k), bus.i_ready, 1);
            chk($sformatf("fill%0d_clken", k),  sr_clken, 1);
        end
        cyc(0, 1, 8'd5, 1, 0);
        chk("p5_occ",    occupancy, 4);
        chk("p5_ovalid", bus.o_valid, 1);
        chk("p5_odata",  bus.o_data, 1);
        chk("p5_clken",  sr_clken, 1);

        // 2: full line, backpressure
        for (int k = 0; k < 2; k++) begin
            cyc(0, 1, 8'd6, 0, 0);
            chk("full_iready", bus.i_ready, 0);
            chk("full_clken",  sr_clken, 0);
            chk("full_occ",    occupancy, 4);
            chk("full_odata",  bus.o_data, 2);
        end
        cyc(0, 1, 8'd6, 1, 0);
        chk("full_rel_clken",  sr_clken, 1);
        chk("full_rel_iready", bus.i_ready, 1);
        chk("full_rel_odata",  bus.o_data, 2);
        cyc(0, 0, 0, 1, 0);
        chk("idle_ovalid", bus.o_valid, 0);
        chk("idle_clken",  sr_clken, 0);
        chk("idle_occ",    occupancy, 4);
        chk_q("t2_out", '{8'd1, 8'd2});

        // 3: flush with occupancy 3, o_ready high
        cyc(1, 0, 0, 1, 0);
        cyc(0, 1, 8'hA1, 1, 0);
        cyc(0, 1, 8'hB2, 1, 0);
        cyc(0, 1, 8'hC3, 1, 0);
        cyc(0, 0, 0, 1, 1);
        outq.delete(); done_cnt = 0;
        chk("f3_req_busy",   flush_busy, 0);
        chk("f3_req_iready", bus.i_ready, 1);
        chk("f3_req_occ",    occupancy, 3);
        cyc(0, 0, 0, 1, 0);
        chk("f3_c1_busy",   flush_busy, 1);
        chk("f3_c1_iready", bus.i_ready, 0);
        chk("f3_c1_ovalid", bus.o_valid, 0);
        chk("f3_c1_clken",  sr_clken, 1);
        chk("f3_c1_si",     sr_si, 0);
        cyc(0, 0, 0, 1, 0);
        chk("f3_c2_ovalid", bus.o_valid, 1);
        chk("f3_c2_odata",  bus.o_data, 8'hA1);
        chk("f3_c2_occ",    occupancy, 3);
        cyc(0, 0, 0, 1, 0);
        chk("f3_c3_odata",  bus.o_data, 8'hB2);
        chk("f3_c3_occ",    occupancy, 2);
        cyc(0, 0, 0, 1, 0);
        chk("f3_c4_odata",  bus.o_data, 8'hC3);
        chk("f3_c4_occ",    occupancy, 1);
        chk("f3_c4_done",   flush_done, 0);
        cyc(0, 0, 0, 1, 0);
        chk("f3_c5_done",   flush_done, 1);
        chk("f3_c5_busy",   flush_busy, 1);
        chk("f3_c5_occ",    occupancy, 0);
        chk("f3_c5_clken",  sr_clken, 0);
        chk("f3_c5_iready", bus.i_ready, 0);
        cyc(0, 0, 0, 1, 0);
        chk("f3_c6_done",   flush_done, 0);
        chk("f3_c6_busy",   flush_busy, 0);
        chk("f3_c6_iready", bus.i_ready, 1);
        chk("f3_done_cnt",  done_cnt, 1);
        chk_q("f3_out", '{8'hA1, 8'hB2, 8'hC3});

        // 4: flush requested with the last accept, o_ready toggling
        cyc(1, 0, 0, 1, 0);
        cyc(0, 1, 8'h11, 1, 0);
        cyc(0, 1, 8'h22, 1, 0);
        cyc(0, 1, 8'h33, 1, 1);
        chk("f4_acc_iready", bus.i_ready, 1);
        chk("f4_acc_clken",  sr_clken, 1);
        outq.delete(); done_cnt = 0; n_clk = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 8'hEE, (i % 2 == 0), 0);
            chk("f4_iready", bus.i_ready, 0);
            if (flush_done) begin
                seen = 1'b1;
                break;
            end
            if (bus.o_valid && !bus.o_ready) chk("f4_stall", sr_clken, 0);
        end
        chk("f4_done_seen", seen, 1);
        cyc(0, 0, 0, 1, 0);
        chk("f4_busy",     flush_busy, 0);
        chk("f4_iready_r", bus.i_ready, 1);
        chk("f4_done_cnt", done_cnt, 1);
        chk("f4_clk_cnt",  n_clk, 5);
        chk_q("f4_out", '{8'h11, 8'h22, 8'h33});

        // 5: flush of an empty line
        cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        chk("f5_occ", occupancy, 0);
        n_clk = 0; done_cnt = 0;
        cyc(0, 1, 8'h77, 1, 0);
        chk("f5_fl_busy",   flush_busy, 1);
        chk("f5_fl_done",   flush_done, 0);
        chk("f5_fl_clken",  sr_clken, 0);
        chk("f5_fl_iready", bus.i_ready, 0);
        cyc(0, 1, 8'h77, 1, 0);
        chk("f5_dn_busy",   flush_busy, 1);
        chk("f5_dn_done",   flush_done, 1);
        chk("f5_dn_clken",  sr_clken, 0);
        chk("f5_dn_iready", bus.i_ready, 0);
        cyc(0, 0, 0, 1, 0);
        chk("f5_run_busy",   flush_busy, 0);
        chk("f5_run_done",   flush_done, 0);
        chk("f5_run_iready", bus.i_ready, 1);
        chk("f5_clk_cnt",    n_clk, 0);
        chk("f5_done_cnt",   done_cnt, 1);

        // 6: reset in the middle of a stalled flush
        cyc(0, 1, 8'h44, 1, 0);
        cyc(0, 1, 8'h55, 1, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("f6_stall_ovalid", bus.o_valid, 1);
        chk("f6_stall_odata",  bus.o_data, 8'h44);
        chk("f6_stall_clken",  sr_clken, 0);
        chk("f6_stall_occ",    occupancy, 2);
        chk("f6_stall_busy",   flush_busy, 1);
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, DATA_BITS'(8'h61 + k), 1, 0);
            if (k == 0) begin
                chk("f6_rst_busy", flush_busy, 0);
                chk("f6_rst_done", flush_done, 0);
                chk("f6_rst_occ",  occupancy, 0);
            end
            chk($sformatf("f6_p%0d_ovalid", k), bus.o_valid, 0);
            chk($sformatf("f6_p%0d_iready", k), bus.i_ready, 1);
        end
        cyc(0, 1, 8'h65, 1, 0);
        chk("f6_p4_ovalid", bus.o_valid, 1);
        chk("f6_p4_odata",  bus.o_data, 8'h61);
        chk("f6_p4_occ",    occupancy, 4);
        cyc(0, 0, 0, 1, 0);
        chk("f6_idle_ovalid", bus.o_valid, 0);
        chk("f6_idle_occ",    occupancy, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
